// File: rtl/nios_sd_loader_key_pio.sv
// Avalon-MM input PIO for the nios_sd_loader pushbuttons: synchronised data readback,
// sticky per-bit edge capture with write-1-to-clear, and a masked level interrupt.
module nios_sd_loader_key_pio #(
  parameter int               WIDTH          = 4,
  parameter int               EDGE_TYPE      = 1,
  parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam logic [1:0] ARM_FULL  = 2'd3;

  logic [WIDTH-1:0] sync1_p0;
  logic [WIDTH-1:0] sync2_p1;
  logic [WIDTH-1:0] prev_p2;
  logic [1:0]       arm_cnt;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic             wr_en;
  logic             armed;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] edge_capture_nxt;
  logic [WIDTH-1:0] rd_word;
  logic             unused_wd;

  function automatic logic [WIDTH-1:0] sel_edge(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] old);
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    rise = cur & ~old;
    fall = ~cur & old;
    case (EDGE_TYPE)
      0:       return rise;
      1:       return fall;
      default: return rise | fall;
    endcase
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous synchronised sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
      prev_p2  <= '0;
    end else begin
      sync1_p0 <= in_port;
      sync2_p1 <= sync1_p0;
      prev_p2  <= sync2_p1;
    end
  end

  // Detection stays off until the flushed-to-zero pipeline has refilled with real input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_FULL) begin
      arm_cnt <= arm_cnt + 2'd1;
    end
  end

  assign wr_en    = chipselect & ~write_n;
  assign armed    = (arm_cnt == ARM_FULL);
  assign edge_det = armed ? sel_edge(sync2_p1, prev_p2) : '0;
  assign clr_bits = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge wins over a same-cycle clear of that bit
  assign edge_capture_nxt = (edge_capture & ~clr_bits) | edge_det;

  // Stage p3: capture, mask and interrupt registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= IRQ_MASK_RESET;
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_capture <= edge_capture_nxt;
      irq          <= |(edge_capture & irq_mask);
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA: rd_word = sync2_p1;
      ADDR_DIR:  rd_word = '0;
      ADDR_MASK: rd_word = irq_mask;
      ADDR_EDGE: rd_word = edge_capture;
      default:   rd_word = '0;
    endcase
    readdata = zext(rd_word);
  end

  assign unused_wd = ^writedata;

endmodule
